// File: rtl/register_file_if.sv
// Register-file access bundle: two operand reads, one write-back write, one debug read.
// Latency: none of its own; carries combinational reads and a 1-cycle write.
// Backpressure: none; the register file accepts a read and a write every cycle.
interface register_file_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] write;
  logic            RegWrite;
  logic [XLEN-1:0] read1;
  logic [XLEN-1:0] read2;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;

  // Datapath side: presents addresses and write-back data, consumes read data.
  modport master (
    output rs1, rs2, rd, write, RegWrite, dbg_addr,
    input  read1, read2, dbg_data
  );

  // Register file side.
  modport slave (
    input  rs1, rs2, rd, write, RegWrite, dbg_addr,
    output read1, read2, dbg_data
  );
endinterface

// File: rtl/register_file.sv
// Integer register file: NREG x XLEN, x0 hardwired to zero, write-through bypass on read ports.
// Latency: reads 0 cycles (combinational), writes commit on the next rising clk.
// Backpressure: none; always accepts one write and three reads per cycle.
module register_file #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave bus
);
  localparam int AW = $clog2(NREG);

  // x0 has no storage; entries start at 1.
  logic [XLEN-1:0] regs [1:NREG-1];

  logic            wr_en;
  logic [XLEN-1:0] read1_d;
  logic [XLEN-1:0] read2_d;
  logic [XLEN-1:0] dbg_d;

  // A write is live only outside reset and never to x0; this also gates the bypass.
  assign wr_en = bus.RegWrite && !reset && (bus.rd != '0);

  // Stored contents for an address, with x0 reading as zero.
  function automatic logic [XLEN-1:0] stored(input logic [AW-1:0] a);
    stored = '0;
    for (int i = 1; i < NREG; i++) begin
      if (a == AW'(i)) stored = regs[i];
    end
  endfunction

  // Reset clears every register and wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 1; i < NREG; i++) begin
        if (bus.rd == AW'(i)) regs[i] <= bus.write;
      end
    end
  end

  // Operand read port 1: forward pending write-back data when addresses match.
  always_comb begin
    read1_d = stored(bus.rs1);
    if (wr_en && (bus.rd == bus.rs1)) read1_d = bus.write;
  end

  // Operand read port 2: same forwarding rule, independent of port 1.
  always_comb begin
    read2_d = stored(bus.rs2);
    if (wr_en && (bus.rd == bus.rs2)) read2_d = bus.write;
  end

  // Debug port shows committed contents only.
  always_comb begin
    dbg_d = stored(bus.dbg_addr);
  end

  assign bus.read1    = read1_d;
  assign bus.read2    = read2_d;
  assign bus.dbg_data = dbg_d;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file against an array-based reference model.
// Latency: model applies writes at the rising edge, reads are evaluated combinationally.
// Backpressure: not applicable.
module tb_register_file;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam logic [XLEN-1:0] STEP = 64'h0101_0101_0101_0101;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [XLEN-1:0] model [NREG];

  register_file_if #(.XLEN(XLEN), .NREG(NREG)) rf_if ();

  register_file #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected operand read: zero for x0, pending write data when it targets a, else stored.
  function automatic logic [XLEN-1:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (!reset && rf_if.RegWrite && rf_if.rd == a) return rf_if.write;
    return model[a];
  endfunction

  // Expected debug read: committed contents only.
  function automatic logic [XLEN-1:0] ref_dbg(input logic [4:0] a);
    if (a == 5'd0) return '0;
    return model[a];
  endfunction

  // Advance one clock, updating the model with what the edge commits; returns at negedge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NREG; i++) model[i] = '0;
    end else if (rf_if.RegWrite && rf_if.rd != 5'd0) begin
      model[rf_if.rd] = rf_if.write;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset          = 1'b0;
    rf_if.RegWrite = 1'b0;
    rf_if.rd       = '0;
    rf_if.write    = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < NREG; a++) begin
      rf_if.rs1      = 5'(a);
      rf_if.rs2      = 5'(NREG - 1 - a);
      rf_if.dbg_addr = 5'(a);
      #1;
      n_checks++;
      if (rf_if.read1 !== '0 || rf_if.read2 !== '0 || rf_if.dbg_data !== '0) begin
        n_errors++;
        $display("FAIL reset_clear a=%0d: read1=%h read2=%h dbg=%h, expected all 0",
                 a, rf_if.read1, rf_if.read2, rf_if.dbg_data);
      end
    end
  endtask

  task automatic test_basic();
    idle();
    rf_if.rd = 5'd2; rf_if.write = 64'd5; rf_if.RegWrite = 1'b1;
    tick();
    rf_if.RegWrite = 1'b0;
    rf_if.rs1 = 5'd1; rf_if.rs2 = 5'd2; rf_if.dbg_addr = 5'd2;
    #1;
    n_checks++;
    if (rf_if.read1 !== 64'd0) begin
      n_errors++; $display("FAIL basic_read1: got %h expected 0", rf_if.read1);
    end
    n_checks++;
    if (rf_if.read2 !== 64'd5) begin
      n_errors++; $display("FAIL basic_read2: got %h expected 5", rf_if.read2);
    end
    n_checks++;
    if (rf_if.dbg_data !== 64'd5) begin
      n_errors++; $display("FAIL basic_dbg: got %h expected 5", rf_if.dbg_data);
    end
  endtask

  task automatic test_bypass();
    idle();
    rf_if.rs2 = 5'd2; rf_if.rd = 5'd2; rf_if.RegWrite = 1'b1; rf_if.write = 64'd5;
    rf_if.dbg_addr = 5'd2;
    #1;
    n_checks++;
    if (rf_if.read2 !== 64'd5) begin
      n_errors++; $display("FAIL bypass_first: got %h expected 5", rf_if.read2);
    end
    rf_if.write = 64'd7;
    #1;
    n_checks++;
    if (rf_if.read2 !== 64'd7) begin
      n_errors++; $display("FAIL bypass_track: got %h expected 7", rf_if.read2);
    end
    tick();
    rf_if.RegWrite = 1'b0;
    rf_if.write = 64'd4;
    #1;
    n_checks++;
    if (rf_if.read2 !== 64'd7) begin
      n_errors++; $display("FAIL bypass_committed: got %h expected 7", rf_if.read2);
    end
    n_checks++;
    if (rf_if.dbg_data !== 64'd7) begin
      n_errors++; $display("FAIL bypass_dbg: got %h expected 7", rf_if.dbg_data);
    end
  endtask

  task automatic test_x0();
    idle();
    rf_if.rd = 5'd0; rf_if.write = '1; rf_if.RegWrite = 1'b1;
    rf_if.rs1 = 5'd0; rf_if.dbg_addr = 5'd0;
    #1;
    n_checks++;
    if (rf_if.read1 !== '0) begin
      n_errors++; $display("FAIL x0_before: got %h expected 0", rf_if.read1);
    end
    tick();
    rf_if.RegWrite = 1'b0;
    for (int a = 0; a < NREG; a++) begin
      rf_if.dbg_addr = 5'(a);
      rf_if.rs1      = 5'(a);
      #1;
      n_checks++;
      if (rf_if.dbg_data !== ref_dbg(5'(a)) || rf_if.read1 !== ref_read(5'(a))) begin
        n_errors++;
        $display("FAIL x0_after a=%0d: dbg=%h read1=%h expected %h",
                 a, rf_if.dbg_data, rf_if.read1, ref_dbg(5'(a)));
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [XLEN-1:0] pre;
    // First with x3 empty, then with x3 holding data: during reset the stored value shows.
    for (int pass = 0; pass < 2; pass++) begin
      idle();
      if (pass == 1) begin
        rf_if.rd = 5'd3; rf_if.write = 64'h33; rf_if.RegWrite = 1'b1;
        tick();
      end
      pre = model[3];
      reset = 1'b1; rf_if.RegWrite = 1'b1; rf_if.rd = 5'd3; rf_if.write = 64'd9;
      rf_if.rs1 = 5'd3; rf_if.dbg_addr = 5'd3;
      #1;
      n_checks++;
      if (rf_if.read1 !== pre) begin
        n_errors++;
        $display("FAIL rst_prio_during pass=%0d: got %h expected %h", pass, rf_if.read1, pre);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (rf_if.dbg_data !== '0 || rf_if.read1 !== '0) begin
        n_errors++;
        $display("FAIL rst_prio_after pass=%0d: dbg=%h read1=%h expected 0",
                 pass, rf_if.dbg_data, rf_if.read1);
      end
    end
  endtask

  task automatic test_sweep();
    idle();
    for (int i = 1; i < NREG; i++) begin
      rf_if.rd = 5'(i); rf_if.write = STEP * 64'(i); rf_if.RegWrite = 1'b1;
      tick();
    end
    idle();
    for (int a = 0; a < NREG; a++) begin
      for (int b = 0; b < NREG; b++) begin
        rf_if.rs1 = 5'(a); rf_if.rs2 = 5'(b); rf_if.dbg_addr = 5'(b);
        #1;
        n_checks++;
        if (rf_if.read1 !== STEP * 64'(a) || rf_if.read2 !== STEP * 64'(b) ||
            rf_if.dbg_data !== STEP * 64'(b)) begin
          n_errors++;
          $display("FAIL sweep a=%0d b=%0d: read1=%h read2=%h dbg=%h expected %h/%h",
                   a, b, rf_if.read1, rf_if.read2, rf_if.dbg_data,
                   STEP * 64'(a), STEP * 64'(b));
        end
      end
    end
  endtask

  task automatic test_random();
    idle();
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 39) == 0);
      rf_if.RegWrite = $urandom_range(0, 1);
      rf_if.rd       = 5'($urandom_range(0, NREG - 1));
      rf_if.write    = {$urandom, $urandom};
      rf_if.rs1      = ($urandom_range(0, 3) == 0) ? rf_if.rd : 5'($urandom_range(0, NREG - 1));
      rf_if.rs2      = ($urandom_range(0, 3) == 0) ? rf_if.rs1 : 5'($urandom_range(0, NREG - 1));
      rf_if.dbg_addr = ($urandom_range(0, 3) == 0) ? rf_if.rd : 5'($urandom_range(0, NREG - 1));
      #1;
      n_checks++;
      if (rf_if.read1 !== ref_read(rf_if.rs1) || rf_if.read2 !== ref_read(rf_if.rs2) ||
          rf_if.dbg_data !== ref_dbg(rf_if.dbg_addr)) begin
        n_errors++;
        $display("FAIL random n=%0d: read1=%h/%h read2=%h/%h dbg=%h/%h (got/expected)",
                 n, rf_if.read1, ref_read(rf_if.rs1), rf_if.read2, ref_read(rf_if.rs2),
                 rf_if.dbg_data, ref_dbg(rf_if.dbg_addr));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    reset = 1'b1;
    rf_if.rs1 = '0; rf_if.rs2 = '0; rf_if.dbg_addr = '0;
    rf_if.rd = '0; rf_if.write = '0; rf_if.RegWrite = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bypass();
    test_x0();
    test_reset_priority();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
